// File: rtl/prng_stream.sv
// Galois-LFSR random word source: seed loading, free-run / one-shot modes,
// and a valid/ready output port delivering one word per OUT_W fresh steps.
module prng_stream #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(16'hACE1),
  parameter int unsigned      OUT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seed_fix
);

  localparam int unsigned      CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
  localparam logic [1:0]       MODE_FREE = 2'b01;
  localparam logic [1:0]       MODE_ONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             seed_fix_q, seed_fix_d;
  logic [WIDTH-1:0] s_step;
  logic             gen_mode;

  // One Galois step; a nonzero state never maps to zero.
  assign s_step   = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
  assign gen_mode = (mode == MODE_FREE) || (mode == MODE_ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    seed_fix_d  = seed_fix_q;

    if (seed_load) begin
      // Zero seed would lock the LFSR, so substitute the default and flag it.
      s_d         = (seed_in == '0) ? SEED_DEFAULT : seed_in;
      seed_fix_d  = (seed_in == '0);
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ena && ((mode == MODE_FREE) || ((mode == MODE_ONE) && req))) begin
            state_d = GEN;
          end
        end
        GEN: begin
          if (ena) begin
            if (gen_mode) begin
              s_d = s_step;
              if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                out_data_d  = s_step[OUT_W-1:0];
                out_valid_d = 1'b1;
                state_d     = FULL;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
        FULL: begin
          // Handoff is independent of ena so a waiting consumer is never stalled.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = (mode == MODE_FREE) ? GEN : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= SEED_DEFAULT;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      seed_fix_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      seed_fix_q  <= seed_fix_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign seed_fix  = seed_fix_q;

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream: hand-derived words and edge counts, plus a
// long free-run compared against a reference step function.
module tb_prng_stream;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  mode;
  logic        req;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        seed_fix;

  int checks;
  int errors;

  prng_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .req       (req),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .seed_fix  (seed_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid is seen; n = number of edges taken.
  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < max_cycles);
    check_eq("valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic load_seed(input logic [15:0] v);
    seed_in   = v;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    int          n;
    logic [15:0] m;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    mode      = 2'b01;
    req       = 1'b0;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h0);
    check_eq("rst_fix", 32'(seed_fix), 32'd0);

    // Free-run from reset: hand-derived first two words, then 1000 model words.
    rst_n = 1'b1;
    m = 16'hACE1;
    for (int w = 0; w < 1000; w++) begin
      for (int k = 0; k < 8; k++) m = ref_step(m);
      wait_valid(20, n);
      check_eq("fr_period", 32'(n), 32'd9);
      check_eq("fr_word", 32'(out_data), 32'(m[7:0]));
      if (w == 0) check_eq("fr_word0", 32'(out_data), 32'hC4);
      if (w == 1) check_eq("fr_word1", 32'(out_data), 32'h62);
    end

    // Zero seed is replaced and flagged.
    load_seed(16'h0000);
    check_eq("z_fix", 32'(seed_fix), 32'd1);
    check_eq("z_valid", 32'(out_valid), 32'd0);
    wait_valid(20, n);
    check_eq("z_lat", 32'(n), 32'd9);
    check_eq("z_word", 32'(out_data), 32'hC4);

    // Load in FULL together with out_ready: load wins, data holds, back to IDLE.
    load_seed(16'h0001);
    check_eq("ld_valid", 32'(out_valid), 32'd0);
    check_eq("ld_fix", 32'(seed_fix), 32'd0);
    check_eq("ld_hold", 32'(out_data), 32'hC4);
    wait_valid(20, n);
    check_eq("ld_lat", 32'(n), 32'd9);
    check_eq("ld_word", 32'(out_data), 32'h68);

    // One-shot with a stalled consumer.
    mode      = 2'b10;
    out_ready = 1'b0;
    load_seed(16'h0000);
    repeat (5) begin
      tick();
      check_eq("os_idle", 32'(out_valid), 32'd0);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_valid(20, n);
    check_eq("os_lat", 32'(n), 32'd8);
    check_eq("os_word", 32'(out_data), 32'hC4);
    repeat (20) begin
      tick();
      check_eq("os_stall_v", 32'(out_valid), 32'd1);
      check_eq("os_stall_d", 32'(out_data), 32'hC4);
    end
    out_ready = 1'b1;
    tick();
    check_eq("os_accept", 32'(out_valid), 32'd0);
    repeat (20) begin
      tick();
      check_eq("os_noreq", 32'(out_valid), 32'd0);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_valid(20, n);
    check_eq("os2_lat", 32'(n), 32'd8);
    check_eq("os2_word", 32'(out_data), 32'h62);
    tick();

    // ena low for 5 cycles after 3 steps: same word, 5 cycles later.
    mode = 2'b01;
    load_seed(16'h0000);
    repeat (4) tick();
    ena = 1'b0;
    repeat (5) begin
      tick();
      check_eq("ena_frozen", 32'(out_valid), 32'd0);
    end
    ena = 1'b1;
    wait_valid(20, n);
    check_eq("ena_lat", 32'(n), 32'd5);
    check_eq("ena_word", 32'(out_data), 32'hC4);

    // Abort after 4 steps, then resume: word is state after 12 steps.
    mode = 2'b00;
    load_seed(16'h0000);
    mode = 2'b01;
    repeat (5) tick();
    mode = 2'b00;
    tick();
    repeat (3) begin
      tick();
      check_eq("ab_idle", 32'(out_valid), 32'd0);
    end
    mode = 2'b01;
    wait_valid(20, n);
    check_eq("ab_lat", 32'(n), 32'd9);
    check_eq("ab_word", 32'(out_data), 32'h2C);

    // Async reset mid-GEN clears outputs before any clock edge.
    load_seed(16'h0000);
    check_eq("ar_fix_pre", 32'(seed_fix), 32'd1);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 32'(out_valid), 32'd0);
    check_eq("ar_data", 32'(out_data), 32'h0);
    check_eq("ar_fix", 32'(seed_fix), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_valid(20, n);
    check_eq("ar_lat", 32'(n), 32'd9);
    check_eq("ar_word", 32'(out_data), 32'hC4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
